instr_fetch_unit: RTL and testbench

- Producer side of the controller's instruction interface.
- Owns the PC and fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Holds the current word on Instr with a valid flag until the execute stage accepts it.
- On acceptance, advances the PC to PC+4 or to the branch target, depending on PCSrc from conditional logic.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/pc_register.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 89 ++++++++
 tb/tb_instr_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_t;

    localparam int          PC_INC     = 4;
    localparam int          R15_OFFSET = 8;
    localparam logic [1:0]  ALIGN_MASK = 2'b00;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: loads PC+4 or the word-aligned branch target on accept.
// PCPlus4/PCPlus8 views are combinational from the held PC.
module pc_register
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                pc_src,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [PC_WIDTH-1:0] pc_plus8,
    output logic                misalign
);

    logic [PC_WIDTH-1:0] pc_next;

    assign pc_plus4 = pc + PC_WIDTH'(PC_INC);
    assign pc_plus8 = pc + PC_WIDTH'(R15_OFFSET);

    always_comb begin
        pc_next = pc_plus4;
        if (pc_src) begin
            pc_next = {target[PC_WIDTH-1:2], 2'b00};
        end
    end

    // Only a taken branch can carry a misaligned target.
    assign misalign = en & pc_src & ~is_word_aligned(target[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (en) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches one instruction word per req/ack handshake and presents it with a
// valid flag until the execute stage accepts it; accept advances the PC.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         Instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                PCSrc,
    input  logic [PC_WIDTH-1:0] ALUResult,
    output logic [PC_WIDTH-1:0] PCPlus4,
    output logic [PC_WIDTH-1:0] PCPlus8,
    output logic                align_fault
);

    fetch_state_t        state;
    logic                accept;
    logic                misalign;
    logic [PC_WIDTH-1:0] pc;

    // PCSrc/ALUResult only matter in the accept cycle; elsewhere they are ignored.
    assign accept    = (state == ISSUE) && instr_ready;
    assign imem_addr = pc;

    pc_register #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .en       (accept),
        .pc_src   (PCSrc),
        .target   (ALUResult),
        .pc       (pc),
        .pc_plus4 (PCPlus4),
        .pc_plus8 (PCPlus8),
        .misalign (misalign)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            Instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            align_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        Instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                end
            endcase
            if (misalign) begin
                align_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scenario bench for instr_fetch_unit with a scoreboard of fetched words.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] ALUResult;
    logic [31:0] PCPlus4;
    logic [31:0] PCPlus8;
    logic        align_fault;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_pc;
    logic        model_fault;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PCSrc       (PCSrc),
        .ALUResult   (ALUResult),
        .PCPlus4     (PCPlus4),
        .PCPlus8     (PCPlus8),
        .align_fault (align_fault)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait for a request, hold ack off for 'waits' cycles, then return 'data'.
    task automatic do_fetch(input int waits, input logic [31:0] data);
        logic [31:0] exp;
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout: got %b expected 1", imem_req);
            return;
        end
        checks++;
        if (imem_addr !== model_pc) begin
            failures++;
            $display("FAIL fetch_addr: got %h expected %h", imem_addr, model_pc);
        end
        for (int w = 0; w < waits; w++) begin
            instr_ready = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== model_pc || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold: got req=%b addr=%h vld=%b expected req=1 addr=%h vld=0",
                         imem_req, imem_addr, instr_valid, model_pc);
            end
        end
        instr_ready = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = data;
        exp_q.push_back(data);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL issue_flags: got vld=%b req=%b expected vld=1 req=0", instr_valid, imem_req);
        end
        exp = exp_q.pop_front();
        checks++;
        if (Instr !== exp) begin
            failures++;
            $display("FAIL instr_data: got %h expected %h", Instr, exp);
        end
        checks++;
        if (PCPlus4 !== model_pc + 32'd4 || PCPlus8 !== model_pc + 32'd8) begin
            failures++;
            $display("FAIL pc_plus: got %h/%h expected %h/%h",
                     PCPlus4, PCPlus8, model_pc + 32'd4, model_pc + 32'd8);
        end
    endtask

    task automatic do_accept(input logic src, input logic [31:0] target);
        instr_ready = 1'b1;
        PCSrc       = src;
        ALUResult   = target;
        if (src) begin
            model_pc = {target[31:2], 2'b00};
            if (target[1:0] != 2'b00) model_fault = 1'b1;
        end else begin
            model_pc = model_pc + 32'd4;
        end
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'($urandom_range(0, 1));
        ALUResult   = $urandom;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== model_pc) begin
            failures++;
            $display("FAIL accept_next: got vld=%b req=%b addr=%h expected vld=0 req=1 addr=%h",
                     instr_valid, imem_req, imem_addr, model_pc);
        end
        checks++;
        if (align_fault !== model_fault) begin
            failures++;
            $display("FAIL align_fault: got %b expected %b", align_fault, model_fault);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || Instr !== 32'h0 || align_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got req=%b vld=%b instr=%h fault=%b expected 0/0/0/0",
                     imem_req, instr_valid, Instr, align_fault);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_req: got %b expected 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || PCPlus8 !== 32'h8) begin
            failures++;
            $display("FAIL first_fetch: got req=%b addr=%h pc8=%h expected 1/00000000/00000008",
                     imem_req, imem_addr, PCPlus8);
        end
    endtask

    task automatic test_zero_wait();
        do_fetch(0, 32'hE281_1001);
        do_accept(1'b0, 32'h0);
    endtask

    task automatic test_wait_backpressure();
        logic [31:0] held;
        do_fetch(3, 32'hA5A5_0004);
        held = Instr;
        for (int i = 0; i < 5; i++) begin
            instr_ready = 1'b0;
            PCSrc       = 1'(i % 2);
            ALUResult   = $urandom;
            imem_ack    = (i == 2);
            imem_rdata  = 32'hDEAD_0000 | 32'(i);
            tick();
            checks++;
            if (Instr !== held || instr_valid !== 1'b1 || imem_req !== 1'b0 || imem_addr !== model_pc) begin
                failures++;
                $display("FAIL backpressure: got instr=%h vld=%b req=%b addr=%h expected %h/1/0/%h",
                         Instr, instr_valid, imem_req, imem_addr, held, model_pc);
            end
        end
        imem_ack = 1'b0;
        do_accept(1'b0, 32'h0);
    endtask

    task automatic test_branch();
        while (model_pc != 32'h10) begin
            do_fetch(0, $urandom);
            do_accept(1'b0, 32'h0);
        end
        do_fetch(1, 32'hEA00_0010);
        do_accept(1'b1, 32'h40);
        do_fetch(0, 32'hEA00_0040);
        do_accept(1'b1, 32'h42);
        for (int i = 0; i < 10; i++) begin
            do_fetch($urandom_range(0, 2), $urandom);
            do_accept(1'($urandom_range(0, 1)), {$urandom} & 32'hFFFF_FFFC);
        end
    endtask

    task automatic test_wrap();
        do_fetch(0, 32'h1111_2222);
        do_accept(1'b1, 32'hFFFF_FFFC);
        do_fetch(0, 32'h3333_4444);
        do_accept(1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_addr: got %h expected 00000000", imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_fetch(0, 32'h5555_AAAA);
        do_accept(1'b0, 32'h0);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0 || align_fault !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got req=%b vld=%b addr=%h fault=%b expected 0/0/00000000/0",
                     imem_req, instr_valid, imem_addr, align_fault);
        end
        tick();
        checks++;
        if (Instr !== 32'h0) begin
            failures++;
            $display("FAIL ack_in_reset: got %h expected 00000000", Instr);
        end
        reset = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (Instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL ack_in_idle: got instr=%h vld=%b req=%b expected 00000000/0/1",
                     Instr, instr_valid, imem_req);
        end
        model_pc    = 32'h0;
        model_fault = 1'b0;
        exp_q.delete();
        do_fetch(2, 32'h7777_0000);
        do_accept(1'b0, 32'h0);
    endtask

    initial begin
        reset       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        ALUResult   = 32'h0;
        model_pc    = 32'h0;
        model_fault = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_backpressure();
        test_branch();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
